// File: rtl/mem_io_responder_pkg.sv
// rtl/mem_io_responder_pkg.sv - shared constants and helpers for the memory/IO responder
package mem_io_responder_pkg;

  localparam logic [17:0] IO_BASE = 18'h30000;
  localparam logic [17:0] IO_UART = IO_BASE;
  localparam logic [17:0] IO_CLK  = IO_BASE + 18'h4;
  localparam logic [1:0]  IO_PAGE = IO_BASE[17:16];
  localparam int          RAM_SIZE = 1 << 17;

  typedef enum logic {
    SRC_IO  = 1'b0,
    SRC_RAM = 1'b1
  } rd_src_e;

  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
    return w[idx*8 +: 8];
  endfunction

endpackage

// File: rtl/mem_io_responder_io_fifo.sv
// rtl/mem_io_responder_io_fifo.sv - synchronous FIFO with occupancy count
module mem_io_responder_io_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [AW:0]      count,
  output logic             dropped
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             full, pop_ok, push_ok;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign pop_ok  = pop && (count_q != '0);
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push_ok = push && (!full || pop_ok);
  assign dropped = push && !push_ok;
  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/mem_io_responder.sv
// rtl/mem_io_responder.sv - CPU byte-bus responder: 128 KB RAM plus UART/counter/stop IO page
module mem_io_responder
  import mem_io_responder_pkg::*;
#(
  parameter int RAM_ADDR_WIDTH = $clog2(RAM_SIZE),
  parameter int TX_DEPTH       = 16,
  parameter int FULL_MARGIN    = 2,
  localparam int CW = $clog2(TX_DEPTH) + 1
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        cpu_en,
  input  logic [31:0] cpu_a,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_din,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        program_stop
);

  logic [17:0]               addr;
  logic                      is_io;
  logic [RAM_ADDR_WIDTH-1:0] ram_idx;
  logic                      unused_addr_bits;

  assign addr             = cpu_a[17:0];
  assign is_io            = (addr[17:16] == IO_PAGE);
  assign ram_idx          = cpu_a[RAM_ADDR_WIDTH-1:0];
  assign unused_addr_bits = ^cpu_a[31:18];

  logic [7:0] ram [2**RAM_ADDR_WIDTH];
  logic [7:0] ram_rdata_q;

  always_ff @(posedge clk_in) begin
    if (cpu_wr) begin
      if (!is_io) ram[ram_idx] <= cpu_dout;
    end else begin
      ram_rdata_q <= ram[ram_idx];
    end
  end

  rd_src_e     rd_src_q, rd_src_d;
  logic [7:0]  io_rdata_q, io_rdata_d;
  logic [31:0] counter_q, counter_d;
  logic [31:0] snapshot_q, snapshot_d;
  logic [7:0]  rx_hold_q, rx_hold_d;
  logic        rx_full_q, rx_full_d;
  logic        stop_q, stop_d;
  logic        overflow_q, overflow_d;
  logic        full_q, full_d;
  logic        program_stop_q, program_stop_d;

  logic          tx_push, tx_pop, tx_dropped;
  logic [7:0]    tx_push_data;
  logic [CW-1:0] tx_count;

  mem_io_responder_io_fifo #(
    .WIDTH (8),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk       (clk_in),
    .rst       (rst_in),
    .push      (tx_push),
    .push_data (tx_push_data),
    .pop       (tx_pop),
    .head      (tx_data),
    .count     (tx_count),
    .dropped   (tx_dropped)
  );

  assign tx_valid       = (tx_count != '0);
  assign tx_pop         = tx_valid && tx_ready;
  assign rx_ready       = !rx_full_q;
  assign io_buffer_full = full_q;
  assign program_stop   = program_stop_q;
  // RAM output is unreset, so the reset value of cpu_din comes from the IO path.
  assign cpu_din        = (rd_src_q == SRC_RAM) ? ram_rdata_q : io_rdata_q;

  always_comb begin
    rd_src_d     = is_io ? SRC_IO : SRC_RAM;
    io_rdata_d   = 8'h00;
    snapshot_d   = snapshot_q;
    rx_hold_d    = rx_hold_q;
    rx_full_d    = rx_full_q;
    stop_d       = stop_q;
    tx_push      = 1'b0;
    tx_push_data = cpu_dout;

    if (is_io && !cpu_wr) begin
      if (addr == IO_UART) begin
        io_rdata_d = rx_full_q ? rx_hold_q : 8'h00;
        rx_full_d  = 1'b0;
      end else if (addr[17:2] == IO_CLK[17:2]) begin
        if (addr[1:0] == 2'd0) begin
          snapshot_d = counter_q;
          io_rdata_d = counter_q[7:0];
        end else begin
          io_rdata_d = word_byte(snapshot_q, addr[1:0]);
        end
      end
    end

    if (is_io && cpu_wr) begin
      if (addr == IO_UART && cpu_dout != 8'h00) begin
        tx_push = 1'b1;
      end else if (addr == IO_CLK) begin
        tx_push      = 1'b1;
        tx_push_data = 8'h00;
        stop_d       = 1'b1;
      end
    end

    if (rx_valid && !rx_full_q) begin
      rx_full_d = 1'b1;
      rx_hold_d = rx_data;
    end

    counter_d      = cpu_en ? counter_q + 32'd1 : counter_q;
    overflow_d     = overflow_q || tx_dropped;
    full_d         = (tx_count >= CW'(TX_DEPTH - FULL_MARGIN));
    // Stop is reported only once the trailing 0x00 has left the FIFO.
    program_stop_d = program_stop_q || (stop_q && tx_count == '0);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rd_src_q       <= SRC_IO;
      io_rdata_q     <= 8'h00;
      counter_q      <= '0;
      snapshot_q     <= '0;
      rx_hold_q      <= 8'h00;
      rx_full_q      <= 1'b0;
      stop_q         <= 1'b0;
      overflow_q     <= 1'b0;
      full_q         <= 1'b0;
      program_stop_q <= 1'b0;
    end else begin
      rd_src_q       <= rd_src_d;
      io_rdata_q     <= io_rdata_d;
      counter_q      <= counter_d;
      snapshot_q     <= snapshot_d;
      rx_hold_q      <= rx_hold_d;
      rx_full_q      <= rx_full_d;
      stop_q         <= stop_d;
      overflow_q     <= overflow_d;
      full_q         <= full_d;
      program_stop_q <= program_stop_d;
    end
  end

endmodule

// File: tb/tb_mem_io_responder.sv
// tb/tb_mem_io_responder.sv - directed self-checking bench for mem_io_responder
module tb_mem_io_responder;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        cpu_en;
  logic [31:0] cpu_a;
  logic        cpu_wr;
  logic [7:0]  cpu_dout;
  logic [7:0]  cpu_din;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        program_stop;

  int checks = 0;
  int errors = 0;
  logic [7:0] tx_log [$];

  mem_io_responder dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .cpu_en         (cpu_en),
    .cpu_a          (cpu_a),
    .cpu_wr         (cpu_wr),
    .cpu_dout       (cpu_dout),
    .cpu_din        (cpu_din),
    .io_buffer_full (io_buffer_full),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_ready       (rx_ready),
    .program_stop   (program_stop)
  );

  always #5 clk_in = ~clk_in;

  // Record each byte that the coming rising edge will hand to the UART.
  always @(negedge clk_in) begin
    #2;
    if (!rst_in && tx_valid && tx_ready) tx_log.push_back(tx_data);
  end

  task automatic bus_write(input logic [31:0] a, input logic [7:0] d);
    cpu_a = a; cpu_wr = 1'b1; cpu_dout = d;
    @(negedge clk_in);
    cpu_a = 32'h0; cpu_wr = 1'b0; cpu_dout = 8'h00;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [7:0] d);
    cpu_a = a; cpu_wr = 1'b0;
    @(negedge clk_in);
    d = cpu_din;
    cpu_a = 32'h0;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
  endtask

  task automatic test_reset();
    rst_in = 1'b1; cpu_en = 1'b0; cpu_a = 32'h0; cpu_wr = 1'b0; cpu_dout = 8'h00;
    tx_ready = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
    repeat (2) @(negedge clk_in);
    checks++; if (cpu_din !== 8'h00) begin errors++; $display("FAIL reset_cpu_din: got %h expected 00", cpu_din); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b expected 0", tx_valid); end
    checks++; if (io_buffer_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", io_buffer_full); end
    checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL reset_rx_ready: got %b expected 1", rx_ready); end
    checks++; if (program_stop !== 1'b0) begin errors++; $display("FAIL reset_stop: got %b expected 0", program_stop); end
    rst_in = 1'b0;
  endtask

  task automatic test_ram();
    logic [7:0] d;
    bus_write(32'h0000_0010, 8'hA5);
    bus_read(32'h0000_0010, d);
    checks++; if (d !== 8'hA5) begin errors++; $display("FAIL ram_rd_10: got %h expected a5", d); end
    bus_write(32'h0001_FFFF, 8'h5C);
    bus_read(32'h0001_FFFF, d);
    checks++; if (d !== 8'h5C) begin errors++; $display("FAIL ram_rd_1ffff: got %h expected 5c", d); end
    bus_read(32'h0002_0010, d);
    checks++; if (d !== 8'hA5) begin errors++; $display("FAIL ram_alias_20010: got %h expected a5", d); end
    bus_read(32'hFFFC_0010, d);
    checks++; if (d !== 8'hA5) begin errors++; $display("FAIL ram_upper_bits: got %h expected a5", d); end
  endtask

  task automatic test_tx_basic();
    tx_ready = 1'b1;
    tx_log.delete();
    bus_write(32'h0003_0000, 8'h48);
    bus_write(32'h0003_0000, 8'h00);
    bus_write(32'h0003_0000, 8'h69);
    repeat (5) @(negedge clk_in);
    checks++; if (tx_log.size() !== 2) begin errors++; $display("FAIL tx_basic_len: got %0d expected 2", tx_log.size()); end
    if (tx_log.size() == 2) begin
      checks++; if (tx_log[0] !== 8'h48) begin errors++; $display("FAIL tx_basic_b0: got %h expected 48", tx_log[0]); end
      checks++; if (tx_log[1] !== 8'h69) begin errors++; $display("FAIL tx_basic_b1: got %h expected 69", tx_log[1]); end
    end
  endtask

  task automatic test_fill();
    tx_ready = 1'b0;
    tx_log.delete();
    for (int i = 1; i <= 14; i++) bus_write(32'h0003_0000, 8'(i));
    checks++; if (io_buffer_full !== 1'b0) begin errors++; $display("FAIL full_early: got %b expected 0", io_buffer_full); end
    bus_write(32'h0003_0000, 8'd15);
    checks++; if (io_buffer_full !== 1'b1) begin errors++; $display("FAIL full_rise: got %b expected 1", io_buffer_full); end
    bus_write(32'h0003_0000, 8'd16);
    checks++; if (dut.overflow_q !== 1'b0) begin errors++; $display("FAIL overflow_early: got %b expected 0", dut.overflow_q); end
    bus_write(32'h0003_0000, 8'd17);
    bus_write(32'h0003_0000, 8'd18);
    checks++; if (dut.overflow_q !== 1'b1) begin errors++; $display("FAIL overflow_set: got %b expected 1", dut.overflow_q); end
    checks++; if (dut.tx_count !== 5'd16) begin errors++; $display("FAIL fill_count: got %0d expected 16", dut.tx_count); end
    tx_ready = 1'b1;
    repeat (20) @(negedge clk_in);
    checks++; if (tx_log.size() !== 16) begin errors++; $display("FAIL drain_len: got %0d expected 16", tx_log.size()); end
    if (tx_log.size() == 16) begin
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (tx_log[i] !== 8'(i + 1)) begin errors++; $display("FAIL drain_byte%0d: got %h expected %h", i, tx_log[i], 8'(i + 1)); end
      end
    end
    checks++; if (io_buffer_full !== 1'b0) begin errors++; $display("FAIL full_fall: got %b expected 0", io_buffer_full); end
  endtask

  task automatic test_counter();
    logic [7:0] d0, d1, d2, d3;
    do_reset();
    cpu_en = 1'b1;
    repeat (1000) @(negedge clk_in);
    bus_read(32'h0003_0004, d0);
    bus_read(32'h0003_0005, d1);
    bus_read(32'h0003_0006, d2);
    bus_read(32'h0003_0007, d3);
    checks++; if (d0 !== 8'hE8) begin errors++; $display("FAIL cnt_byte0: got %h expected e8", d0); end
    checks++; if ({d3, d2, d1, d0} !== 32'd1000) begin errors++; $display("FAIL cnt_snapshot: got %0d expected 1000", {d3, d2, d1, d0}); end
    checks++; if (dut.counter_q !== 32'd1004) begin errors++; $display("FAIL cnt_live: got %0d expected 1004", dut.counter_q); end
    cpu_en = 1'b0;
    force dut.counter_q = 32'hFFFF_FFFF;
    @(posedge clk_in);
    #1 release dut.counter_q;
    @(negedge clk_in);
    bus_read(32'h0003_0004, d0);
    bus_read(32'h0003_0007, d3);
    checks++; if ({d3, d0} !== 16'hFFFF) begin errors++; $display("FAIL cnt_forced: got %h expected ffff", {d3, d0}); end
    cpu_en = 1'b1;
    @(negedge clk_in);
    cpu_en = 1'b0;
    bus_read(32'h0003_0004, d0);
    bus_read(32'h0003_0007, d3);
    checks++; if ({d3, d0} !== 16'h0000) begin errors++; $display("FAIL cnt_wrap: got %h expected 0000", {d3, d0}); end
  endtask

  task automatic test_rx();
    logic [7:0] d;
    rx_data = 8'h31; rx_valid = 1'b1;
    @(negedge clk_in);
    rx_valid = 1'b0;
    checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL rx_ready_low: got %b expected 0", rx_ready); end
    bus_read(32'h0003_0000, d);
    checks++; if (d !== 8'h31) begin errors++; $display("FAIL rx_pop: got %h expected 31", d); end
    checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL rx_ready_high: got %b expected 1", rx_ready); end
    bus_read(32'h0003_0000, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL rx_empty: got %h expected 00", d); end
    rx_data = 8'h42; rx_valid = 1'b1;
    @(negedge clk_in);
    rx_valid = 1'b0;
    bus_read(32'h0003_0000, d);
    checks++; if (d !== 8'h42) begin errors++; $display("FAIL rx_second: got %h expected 42", d); end
  endtask

  task automatic test_stop();
    int waited;
    do_reset();
    tx_ready = 1'b0;
    tx_log.delete();
    bus_write(32'h0003_0000, 8'h11);
    bus_write(32'h0003_0000, 8'h22);
    bus_write(32'h0003_0000, 8'h33);
    bus_write(32'h0003_0004, 8'h7E);
    checks++; if (program_stop !== 1'b0) begin errors++; $display("FAIL stop_queued: got %b expected 0", program_stop); end
    tx_ready = 1'b1;
    waited = 0;
    while (tx_valid && waited < 50) begin
      @(negedge clk_in);
      waited++;
    end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL stop_drain_timeout: got tx_valid %b expected 0", tx_valid); end
    checks++; if (program_stop !== 1'b0) begin errors++; $display("FAIL stop_not_early: got %b expected 0", program_stop); end
    @(negedge clk_in);
    checks++; if (program_stop !== 1'b1) begin errors++; $display("FAIL stop_rise: got %b expected 1", program_stop); end
    checks++; if (tx_log.size() !== 4) begin errors++; $display("FAIL stop_len: got %0d expected 4", tx_log.size()); end
    if (tx_log.size() == 4) begin
      checks++;
      if ({tx_log[0], tx_log[1], tx_log[2], tx_log[3]} !== 32'h1122_3300) begin
        errors++; $display("FAIL stop_seq: got %h%h%h%h expected 11223300", tx_log[0], tx_log[1], tx_log[2], tx_log[3]);
      end
    end
  endtask

  task automatic test_reset_mid();
    tx_ready = 1'b0;
    bus_write(32'h0003_0000, 8'h55);
    checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL mid_tx_pending: got %b expected 1", tx_valid); end
    checks++; if (program_stop !== 1'b1) begin errors++; $display("FAIL mid_stop_sticky: got %b expected 1", program_stop); end
    #2 rst_in = 1'b1;
    #1;
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL mid_tx_async: got %b expected 0", tx_valid); end
    checks++; if (program_stop !== 1'b0) begin errors++; $display("FAIL mid_stop_async: got %b expected 0", program_stop); end
    @(negedge clk_in);
    rst_in = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ram();
    test_tx_basic();
    test_fill();
    test_counter();
    test_rx();
    test_stop();
    test_reset_mid();
    repeat (2) @(negedge clk_in);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
